// File: rtl/bus_protocol_master.sv
`default_nettype none
// ============================================================================
// Module      : bus_protocol_master
// Description : Transmitter for the dValid/dAck transfer protocol. Words
//               pushed from a local producer are buffered in a small FIFO
//               and issued one at a time on data/dValid. Each transfer holds
//               dValid for MIN_VALID..MAX_VALID cycles and ends on an
//               accepted dAck (done) or on timeout (err_timeout, word
//               dropped). A one-cycle GAP with dValid low separates
//               transfers.
// Ports       : clk, reset_n (async, active-low)
//               in_valid/in_ready/in_data : upstream push interface
//               dValid/data (registered), dAck : protocol bus
//               busy, fifo_count            : status
//               done, err_early, err_timeout: one-cycle event pulses
// Options     : BUS_PROTOCOL_SVA_EN compiles in embedded protocol assertions.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_protocol_master #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int MIN_VALID = 2,
    parameter int MAX_VALID = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   dValid,
    output logic [DATA_W-1:0]      data,
    input  logic                   dAck,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   done,
    output logic                   err_early,
    output logic                   err_timeout
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_vcnt_w = $clog2(MAX_VALID + 1);

    localparam logic [c_cnt_w-1:0]  c_depth = c_cnt_w'(DEPTH);
    localparam logic [c_vcnt_w-1:0] c_min   = c_vcnt_w'(MIN_VALID);
    localparam logic [c_vcnt_w-1:0] c_max   = c_vcnt_w'(MAX_VALID);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    // Number of cycles dValid has been high, including the current one.
    logic [c_vcnt_w-1:0]  r_vcnt, w_vcnt_nxt;
    logic                 r_dvalid, w_dvalid_nxt;
    logic [DATA_W-1:0]    r_data;
    logic                 r_done, w_done_nxt;
    logic                 r_early, w_early_nxt;
    logic                 r_tmo, w_tmo_nxt;
    logic                 w_full, w_empty, w_push, w_pop;

    assign w_full     = (r_count == c_depth);
    assign w_empty    = (r_count == '0);
    // in_ready depends only on occupancy, so a simultaneous pop never
    // opens a slot in the same cycle.
    assign w_push     = in_valid && !w_full;

    assign in_ready    = !w_full;
    assign fifo_count  = r_count;
    assign busy        = (r_state != ST_IDLE) || !w_empty;
    assign dValid      = r_dvalid;
    assign data        = r_data;
    assign done        = r_done;
    assign err_early   = r_early;
    assign err_timeout = r_tmo;

    // ------------------------------------------------------------------
    // Next-state and registered-output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_vcnt_nxt   = r_vcnt;
        w_dvalid_nxt = r_dvalid;
        w_pop        = 1'b0;
        w_done_nxt   = 1'b0;
        w_early_nxt  = 1'b0;
        w_tmo_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_dvalid_nxt = 1'b1;
                    w_vcnt_nxt   = c_vcnt_w'(1);
                    w_state_nxt  = ST_VALID;
                end
            end
            ST_VALID: begin
                // An ack is honoured once the word has been up for at least
                // MIN_VALID cycles; it takes priority over the timeout so an
                // ack in the final allowed cycle still completes the transfer.
                if (dAck && (r_vcnt >= c_min)) begin
                    w_dvalid_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_GAP;
                end else if (r_vcnt == c_max) begin
                    w_dvalid_nxt = 1'b0;
                    w_tmo_nxt    = 1'b1;
                    w_state_nxt  = ST_GAP;
                end else begin
                    w_early_nxt = dAck;
                    w_vcnt_nxt  = r_vcnt + c_vcnt_w'(1);
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, FIFO control and bus registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_vcnt   <= '0;
            r_dvalid <= 1'b0;
            r_data   <= '0;
            r_done   <= 1'b0;
            r_early  <= 1'b0;
            r_tmo    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_vcnt   <= w_vcnt_nxt;
            r_dvalid <= w_dvalid_nxt;
            r_done   <= w_done_nxt;
            r_early  <= w_early_nxt;
            r_tmo    <= w_tmo_nxt;
            if (w_pop) begin
                r_data   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

`ifdef BUS_PROTOCOL_SVA_EN
    a_len_max: assert property (@(posedge clk) disable iff (!reset_n)
        r_dvalid |-> (r_vcnt >= c_vcnt_w'(1)) && (r_vcnt <= c_max))
        else $display($stime, " bus_protocol_master: dValid exceeded MAX_VALID");

    a_len_min: assert property (@(posedge clk) disable iff (!reset_n)
        $fell(r_dvalid) |-> ($past(r_vcnt) >= c_min))
        else $display($stime, " bus_protocol_master: dValid shorter than MIN_VALID");

    a_data_known: assert property (@(posedge clk) disable iff (!reset_n)
        r_dvalid |-> !$isunknown(r_data))
        else $display($stime, " bus_protocol_master: data unknown while dValid");

    a_data_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (r_dvalid && $past(r_dvalid)) |-> $stable(r_data))
        else $display($stime, " bus_protocol_master: data changed while dValid");

    a_ack_fall: assert property (@(posedge clk) disable iff (!reset_n)
        (r_state == ST_VALID && dAck && r_vcnt >= c_min) |=> !r_dvalid)
        else $display($stime, " bus_protocol_master: dValid did not fall after ack");

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
        w_full |-> !w_push)
        else $display($stime, " bus_protocol_master: push while full");

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n)
        w_empty |-> !w_pop)
        else $display($stime, " bus_protocol_master: pop while empty");
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_protocol_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_protocol_master
// Description : Directed self-checking bench for bus_protocol_master. Drives
//               a default-parameter instance and a 32-bit MIN3/MAX6 instance
//               and compares against hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_protocol_master;

    logic        clk = 1'b0;
    logic        reset_n;

    // default instance: DATA_W=8, DEPTH=4, MIN_VALID=2, MAX_VALID=4
    logic        d_in_valid, d_in_ready, d_dvalid, d_ack, d_busy;
    logic        d_done, d_early, d_tmo;
    logic [7:0]  d_in_data, d_data;
    logic [2:0]  d_count;

    // wide instance: DATA_W=32, DEPTH=4, MIN_VALID=3, MAX_VALID=6
    logic        w_in_valid, w_in_ready, w_dvalid, w_ack, w_busy;
    logic        w_done, w_early, w_tmo;
    logic [31:0] w_in_data, w_data;
    logic [2:0]  w_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bus_protocol_master u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .dValid(d_dvalid), .data(d_data), .dAck(d_ack),
        .busy(d_busy), .fifo_count(d_count),
        .done(d_done), .err_early(d_early), .err_timeout(d_tmo)
    );

    bus_protocol_master #(.DATA_W(32), .DEPTH(4), .MIN_VALID(3), .MAX_VALID(6)) u_dut_w (
        .clk(clk), .reset_n(reset_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .dValid(w_dvalid), .data(w_data), .dAck(w_ack),
        .busy(w_busy), .fifo_count(w_count),
        .done(w_done), .err_early(w_early), .err_timeout(w_tmo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur_valid(input bit sel);
        return sel ? w_dvalid : d_dvalid;
    endfunction

    function automatic logic cur_ready(input bit sel);
        return sel ? w_in_ready : d_in_ready;
    endfunction

    function automatic logic [31:0] cur_data(input bit sel);
        return sel ? w_data : {24'h0, d_data};
    endfunction

    task automatic set_ack(input bit sel, input logic v);
        if (sel) w_ack = v;
        else     d_ack = v;
    endtask

    // Holds in_valid until the word is taken, bounded.
    task automatic push(input bit sel, input logic [31:0] word);
        logic acc;
        acc = 1'b0;
        if (sel) begin w_in_valid = 1'b1; w_in_data = word;       end
        else     begin d_in_valid = 1'b1; d_in_data = word[7:0];  end
        for (int i = 0; i < 20; i++) begin
            if (cur_ready(sel)) begin
                tick;
                acc = 1'b1;
                break;
            end
            tick;
        end
        w_in_valid = 1'b0;
        d_in_valid = 1'b0;
        check("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_level(input bit sel, input logic lvl, input string tag);
        for (int i = 0; i < 20; i++) begin
            if (cur_valid(sel) == lvl) break;
            tick;
        end
        check(tag, 32'(cur_valid(sel)), 32'(lvl));
    endtask

    // Entered in the first cycle dValid is high; drives dAck from mask bit k
    // in transfer cycle k and measures the high length and the event pulses.
    task automatic xfer(input bit sel, input int mask, output int len,
                        output int n_early, output int n_done, output int n_tmo,
                        output logic stable);
        logic [31:0] d0;
        d0 = cur_data(sel);
        len = 0; n_early = 0; n_done = 0; n_tmo = 0; stable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            set_ack(sel, mask[k]);
            tick;
            len++;
            if (cur_data(sel) !== d0) stable = 1'b0;
            if (sel ? w_early : d_early) n_early++;
            if (sel ? w_done  : d_done)  n_done++;
            if (sel ? w_tmo   : d_tmo)   n_tmo++;
            if (!cur_valid(sel)) break;
        end
        set_ack(sel, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len, ne, nd, nt, gap;
        logic st, stale;

        reset_n = 1'b0;
        d_in_valid = 1'b0; d_in_data = '0; d_ack = 1'b0;
        w_in_valid = 1'b0; w_in_data = '0; w_ack = 1'b0;
        tick;
        tick;

        // ---------------- reset state ----------------
        check("rst_dvalid",   32'(d_dvalid),   32'd0);
        check("rst_data",     32'(d_data),     32'd0);
        check("rst_in_ready", 32'(d_in_ready), 32'd1);
        check("rst_count",    32'(d_count),    32'd0);
        check("rst_busy",     32'(d_busy),     32'd0);
        check("rst_pulses",   32'({d_done, d_early, d_tmo}), 32'd0);
        reset_n = 1'b1;
        tick;

        // ---------------- ack at k=1 ----------------
        push(1'b0, 32'hA5);
        check("t1_count",   32'(d_count),  32'd1);
        check("t1_latency", 32'(d_dvalid), 32'd0);
        tick;
        check("t1_rise", 32'(d_dvalid), 32'd1);
        check("t1_data", cur_data(1'b0), 32'hA5);
        xfer(1'b0, 32'h2, len, ne, nd, nt, st);
        check("t1_len",    32'(len), 32'd2);
        check("t1_done",   32'(nd),  32'd1);
        check("t1_early",  32'(ne),  32'd0);
        check("t1_tmo",    32'(nt),  32'd0);
        check("t1_stable", 32'(st),  32'd1);
        check("t1_gap_busy", 32'(d_busy), 32'd1);
        tick;
        check("t1_gap_low",   32'(d_dvalid), 32'd0);
        check("t1_done_once", 32'(d_done),   32'd0);
        check("t1_hold_data", cur_data(1'b0), 32'hA5);
        check("t1_idle_busy", 32'(d_busy),   32'd0);

        // ---------------- early ack at k=0, ack at k=2 ----------------
        push(1'b0, 32'h3C);
        wait_level(1'b0, 1'b1, "t2_wait");
        check("t2_data", cur_data(1'b0), 32'h3C);
        xfer(1'b0, 32'h5, len, ne, nd, nt, st);
        check("t2_len",   32'(len), 32'd3);
        check("t2_early", 32'(ne),  32'd1);
        check("t2_done",  32'(nd),  32'd1);
        check("t2_tmo",   32'(nt),  32'd0);

        // ---------------- timeout, then next word after GAP+IDLE ----------------
        push(1'b0, 32'h11);
        push(1'b0, 32'h22);
        wait_level(1'b0, 1'b1, "t3_wait");
        check("t3_data0", cur_data(1'b0), 32'h11);
        xfer(1'b0, 32'h0, len, ne, nd, nt, st);
        check("t3_len",  32'(len), 32'd4);
        check("t3_tmo",  32'(nt),  32'd1);
        check("t3_done", 32'(nd),  32'd0);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            gap++;
            if (d_dvalid) break;
        end
        check("t3_gap",   32'(gap),      32'd2);
        check("t3_data1", cur_data(1'b0), 32'h22);
        check("t3_count", 32'(d_count),  32'd0);
        xfer(1'b0, 32'h2, len, ne, nd, nt, st);
        check("t3_len1",  32'(len), 32'd2);
        check("t3_done1", 32'(nd),  32'd1);

        // ---------------- ack in the last allowed cycle ----------------
        push(1'b0, 32'h5A);
        wait_level(1'b0, 1'b1, "t3b_wait");
        xfer(1'b0, 32'h8, len, ne, nd, nt, st);
        check("t3b_len",  32'(len), 32'd4);
        check("t3b_done", 32'(nd),  32'd1);
        check("t3b_tmo",  32'(nt),  32'd0);

        // ---------------- fill the FIFO behind a stalled transfer ----------------
        push(1'b0, 32'hFF);
        wait_level(1'b0, 1'b1, "t4_wait_dummy");
        for (int i = 0; i < 4; i++) begin
            d_in_valid = 1'b1;
            d_in_data  = 8'(i);
            tick;
        end
        check("t4_full_count", 32'(d_count),    32'd4);
        check("t4_not_ready",  32'(d_in_ready), 32'd0);
        check("t4_dummy_tmo",  32'(d_tmo),      32'd1);
        d_in_data = 8'd4;
        tick;
        check("t4_hold_full", 32'(d_count), 32'd4);
        tick;
        check("t4_pop_full",  32'(d_count),  32'd3);
        check("t4_issue0",    32'(d_dvalid), 32'd1);
        tick;
        check("t4_push5",     32'(d_count),  32'd4);
        d_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_level(1'b0, 1'b1, "t4_wait");
            check("t4_order", cur_data(1'b0), 32'(i));
            d_ack = 1'b1;
            wait_level(1'b0, 1'b0, "t4_fall");
            d_ack = 1'b0;
        end
        check("t4_drained", 32'(d_count), 32'd0);
        tick;
        check("t4_idle_busy", 32'(d_busy), 32'd0);

        // ---------------- reset in the middle of a transfer ----------------
        push(1'b0, 32'h77);
        push(1'b0, 32'h88);
        check("t5_rise", 32'(d_dvalid), 32'd1);
        tick;
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_dvalid", 32'(d_dvalid),   32'd0);
        check("t5_async_count",  32'(d_count),    32'd0);
        check("t5_async_busy",   32'(d_busy),     32'd0);
        check("t5_async_ready",  32'(d_in_ready), 32'd1);
        check("t5_async_data",   32'(d_data),     32'd0);
        tick;
        tick;
        reset_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (d_dvalid || (d_count != 3'd0)) stale = 1'b1;
        end
        check("t5_no_stale", 32'(stale), 32'd0);

        // ---------------- 32-bit, MIN_VALID=3, MAX_VALID=6 ----------------
        push(1'b1, 32'hDEADBEEF);
        wait_level(1'b1, 1'b1, "t6_wait0");
        check("t6_data0", cur_data(1'b1), 32'hDEADBEEF);
        xfer(1'b1, 32'h20, len, ne, nd, nt, st);
        check("t6_len0",    32'(len), 32'd6);
        check("t6_done0",   32'(nd),  32'd1);
        check("t6_stable0", 32'(st),  32'd1);

        push(1'b1, 32'h12345678);
        wait_level(1'b1, 1'b1, "t6_wait1");
        xfer(1'b1, 32'h2, len, ne, nd, nt, st);
        check("t6_len1",   32'(len), 32'd6);
        check("t6_early1", 32'(ne),  32'd1);
        check("t6_tmo1",   32'(nt),  32'd1);
        check("t6_done1",  32'(nd),  32'd0);

        push(1'b1, 32'hCAFEF00D);
        wait_level(1'b1, 1'b1, "t6_wait2");
        xfer(1'b1, 32'h4, len, ne, nd, nt, st);
        check("t6_len2",    32'(len), 32'd3);
        check("t6_done2",   32'(nd),  32'd1);
        check("t6_early2",  32'(ne),  32'd0);
        check("t6_stable2", 32'(st),  32'd1);
        check("t6_data2",   cur_data(1'b1), 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
